// File: rtl/gate_stim_checker.sv
// Stimulus-and-check initiator for 2-input gate cells: sweeps {a,b} through 00..11,
// samples y_i after a settle time and counts mismatches. Macro GATE_STIM_CHECKER_FAILMASK_EN enables fail_mask.
module gate_stim_checker #(
  parameter int          SETTLE_CYCLES = 2,
  parameter int          PASSES        = 1,
  parameter logic [3:0]  EXPECT_FN     = 4'b0001,
  parameter int          ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             y_i,
  output logic             a_o,
  output logic             b_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       fail_mask
);

  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [PC_W-1:0] PASS_LAST   = PC_W'(PASSES - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [SC_W-1:0]  sc_q, sc_d;
  logic             a_q, a_d, b_q, b_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             mismatch;
  logic [ERR_W-1:0] err_inc;
  logic [1:0]       idx_nxt;

`ifdef GATE_STIM_CHECKER_FAILMASK_EN
  logic [3:0] mask_q, mask_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pc_q    <= '0;
      sc_q    <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
`ifdef GATE_STIM_CHECKER_FAILMASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pc_q    <= pc_d;
      sc_q    <= sc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
`ifdef GATE_STIM_CHECKER_FAILMASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  always_comb begin
    mismatch = (y_i != EXPECT_FN[idx_q]);
    err_inc  = (mismatch && (err_q != '1)) ? err_q + 1'b1 : err_q;
    idx_nxt  = idx_q + 2'd1;

    state_d = state_q;
    idx_d   = idx_q;
    pc_d    = pc_q;
    sc_d    = sc_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
`ifdef GATE_STIM_CHECKER_FAILMASK_EN
    mask_d  = mask_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          pc_d    = '0;
          sc_d    = '0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
`ifdef GATE_STIM_CHECKER_FAILMASK_EN
          mask_d  = '0;
`endif
        end
      end
      RUN: begin
        if (sc_q == SETTLE_LAST) begin
          // Sample edge: score the held vector and apply the next one on the same edge.
          sc_d  = '0;
          err_d = err_inc;
`ifdef GATE_STIM_CHECKER_FAILMASK_EN
          mask_d = mask_q | (mismatch ? (4'b0001 << idx_q) : 4'b0000);
`endif
          if ((idx_q == 2'd3) && (pc_q == PASS_LAST)) begin
            state_d = FINISH;
            idx_d   = '0;
            pc_d    = '0;
            a_d     = 1'b0;
            b_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_inc == '0);
          end else begin
            idx_d = idx_nxt;
            a_d   = idx_nxt[1];
            b_d   = idx_nxt[0];
            if (idx_q == 2'd3) pc_d = pc_q + 1'b1;
          end
        end else begin
          sc_d = sc_q + 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;
`ifdef GATE_STIM_CHECKER_FAILMASK_EN
  assign fail_mask = mask_q;
`else
  assign fail_mask = 4'b0000;
`endif

endmodule

// File: tb/tb_gate_stim_checker.sv
// Bench for gate_stim_checker: three configurations driven by behavioural gate models,
// checked cycle by cycle against expectations derived from the sweep rules.
module tb_gate_stim_checker;

  logic       clk;
  logic       rst;
  logic [2:0] start, y, a, b, busy, done, pass;
  logic [7:0] e0, e2;
  logic [2:0] e1;
  logic [3:0] m0, m1, m2;
  logic [3:0] tt [3];

  int total = 0;
  int bad   = 0;

  gate_stim_checker dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .y_i(y[0]), .a_o(a[0]), .b_o(b[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(e0), .fail_mask(m0));

  gate_stim_checker #(.PASSES(3), .ERR_W(3)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .y_i(y[1]), .a_o(a[1]), .b_o(b[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(e1), .fail_mask(m1));

  gate_stim_checker #(.SETTLE_CYCLES(1), .EXPECT_FN(4'b1000)) dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .y_i(y[2]), .a_o(a[2]), .b_o(b[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_cnt(e2), .fail_mask(m2));

  // Gates under test: truth tables indexed by {a,b}
  assign y[0] = tt[0][{a[0], b[0]}];
  assign y[1] = tt[1][{a[1], b[1]}];
  assign y[2] = tt[2][{a[2], b[2]}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int s_of(input int w);
    return (w == 2) ? 1 : 2;
  endfunction
  function automatic int p_of(input int w);
    return (w == 1) ? 3 : 1;
  endfunction
  function automatic logic [3:0] ex_of(input int w);
    return (w == 2) ? 4'b1000 : 4'b0001;
  endfunction
  function automatic int emax_of(input int w);
    return (w == 1) ? 7 : 255;
  endfunction
  function automatic logic [31:0] err_of(input int w);
    case (w)
      0:       return 32'(e0);
      1:       return 32'(e1);
      default: return 32'(e2);
    endcase
  endfunction
  function automatic logic [3:0] mask_of(input int w);
    case (w)
      0:       return m0;
      1:       return m1;
      default: return m2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full run on DUT w with gate truth table t; restart_k >= 0 re-pulses start mid-run.
  task automatic run(input int w, input logic [3:0] t, input int restart_k);
    int s, p, n, e, v;
    logic [3:0] ex, m, mexp;
    s = s_of(w); p = p_of(w); ex = ex_of(w); n = 4 * p * s;
    e = 0; m = 4'b0000;
    for (int pp = 0; pp < p; pp++)
      for (int vv = 0; vv < 4; vv++)
        if (t[vv] != ex[vv]) begin
          e++;
          m[vv] = 1'b1;
        end
    if (e > emax_of(w)) e = emax_of(w);
`ifdef GATE_STIM_CHECKER_FAILMASK_EN
    mexp = m;
`else
    mexp = 4'b0000;
`endif
    tt[w] = t;
    @(negedge clk);
    start[w] = 1'b1;
    @(posedge clk);
    #1 start[w] = 1'b0;
    for (int k = 0; k < n; k++) begin
      v = (k / s) % 4;
      check("vec_a", 32'(a[w]), 32'(v >> 1));
      check("vec_b", 32'(b[w]), 32'(v & 1));
      check("run_busy", 32'(busy[w]), 1);
      check("run_done", 32'(done[w]), 0);
      check("run_pass", 32'(pass[w]), 0);
      if (k == restart_k) start[w] = 1'b1;
      @(posedge clk);
      #1 start[w] = 1'b0;
    end
    check("fin_done", 32'(done[w]), 1);
    check("fin_busy", 32'(busy[w]), 0);
    check("fin_a", 32'(a[w]), 0);
    check("fin_b", 32'(b[w]), 0);
    check("fin_err", err_of(w), 32'(e));
    check("fin_pass", 32'(pass[w]), (e == 0) ? 1 : 0);
    check("fin_mask", 32'(mask_of(w)), 32'(mexp));
    @(posedge clk);
    #1;
    check("idle_done", 32'(done[w]), 0);
    check("idle_busy", 32'(busy[w]), 0);
    check("hold_err", err_of(w), 32'(e));
    check("hold_pass", 32'(pass[w]), (e == 0) ? 1 : 0);
    check("hold_mask", 32'(mask_of(w)), 32'(mexp));
  endtask

  initial begin
    rst = 1'b1;
    start = '0;
    tt[0] = 4'b0001; tt[1] = 4'b0001; tt[2] = 4'b1000;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      check("rst_a", 32'(a[w]), 0);
      check("rst_b", 32'(b[w]), 0);
      check("rst_busy", 32'(busy[w]), 0);
      check("rst_done", 32'(done[w]), 0);
      check("rst_pass", 32'(pass[w]), 0);
      check("rst_err", err_of(w), 0);
      check("rst_mask", 32'(mask_of(w)), 0);
    end
    rst = 1'b0;

    run(0, 4'b0001, -1);   // correct NOR
    run(0, 4'b0000, -1);   // stuck at 0
    run(1, 4'b1110, -1);   // OR against NOR, 3 passes, saturates
    run(2, 4'b1000, -1);   // AND against AND expectation
    run(0, 4'b0001, 2);    // start re-pulsed at edge E0+3 is ignored

    // Reset mid-run: y stuck at 0 gives one mismatch before the abort
    tt[0] = 4'b0000;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_a", 32'(a[0]), 1);
    check("pre_rst_err", err_of(0), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy[0]), 0);
    check("arst_a", 32'(a[0]), 0);
    check("arst_b", 32'(b[0]), 0);
    check("arst_err", err_of(0), 0);
    check("arst_done", 32'(done[0]), 0);
    repeat (2) begin
      @(negedge clk);
      check("arst_hold_done", 32'(done[0]), 0);
      check("arst_hold_busy", 32'(busy[0]), 0);
    end
    rst = 1'b0;
    run(0, 4'b0001, -1);

    for (int i = 0; i < 8; i++) begin
      int w;
      logic [3:0] t;
      w = int'($urandom_range(0, 2));
      t = 4'($urandom_range(0, 15));
      run(w, t, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_stim_checker.md
Name: gate_stim_checker

Overview:
- Stimulus-and-check initiator for the team's 2-input gate cells (a, b -> y interface).
- Drives a/b through all four input combinations, waits a settle time, samples y and compares it against a parameterised truth table.
- Counts mismatches and reports pass/fail.
- Sits beside the gate under test on the lab board; the gate's own y output feeds back into y_i.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before y_i is sampled; legal range >= 1.
- PASSES, 1, number of full 4-vector sweeps per run; legal range >= 1.
- EXPECT_FN, 4'b0001, expected y per vector, bit index {a,b}; default is NOR.
- ERR_W, 8, width of the mismatch counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle run request; honoured only in IDLE.
- y_i  input  1  output of the gate under test.
- a_o  output  1  stimulus a (registered).
- b_o  output  1  stimulus b (registered).
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse at run end.
- pass  output  1  high when the last run had zero mismatches; held until the next start.
- err_cnt  output  ERR_W  mismatch count of the last run; saturating.
- fail_mask  output  4  per-vector fail flags; see Optional Feature.

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous, active-high.
- Reset values: a_o=0, b_o=0, busy=0, done=0, pass=0, err_cnt=0, fail_mask=0, state=IDLE, vector index=0, pass counter=0, settle counter=0.
- Reset mid-run: abort immediately to the reset values. No done pulse is produced.
- States: IDLE, RUN, FINISH.
- IDLE:
  - If start=1 at edge E0: apply vector 0 (a_o=0, b_o=0).
  - Clear err_cnt and fail_mask, set pass=0, busy=1, state -> RUN.
  - If start=0: hold.
- RUN:
  - Vector order 00, 01, 10, 11, with a=idx[1] and b=idx[0]. Each vector is held exactly SETTLE_CYCLES cycles.
  - A vector applied at edge E is sampled at edge E+SETTLE_CYCLES. On that same edge the next vector is applied.
  - Mismatch test: y_i != EXPECT_FN[idx]. On a mismatch, err_cnt increments, saturating at 2^ERR_W-1.
  - After idx=3, wrap to idx=0 and increment the pass counter.
  - The sample of vector 3 in the final pass goes to FINISH. a_o and b_o return to 0 on that edge.
  - Last sample edge = E0 + 4*PASSES*SETTLE_CYCLES.
- FINISH:
  - Lasts one cycle. done=1 and busy=0 during it.
  - pass = (err_cnt==0), including the last sample's result.
  - Next edge: state -> IDLE, done=0.
- start handling:
  - start is ignored in RUN and FINISH; it is not queued.
  - start and rst together: rst wins.
- Latency: done is high for the cycle following edge E0 + 4*PASSES*SETTLE_CYCLES.
- Synchronisation: y_i is treated as synchronous to clk. There is no synchroniser; the settle time covers the combinational delay of the gate under test.
- Saturation: err_cnt never wraps. pass is 0 whenever err_cnt is nonzero.

Optional Feature:
- Macro: GATE_STIM_CHECKER_FAILMASK_EN.
- Defined:
  - fail_mask[idx] is set on any mismatch of vector idx, in any pass.
  - fail_mask is cleared on start and held after done until the next start.
- Undefined:
  - The fail_mask port still exists and is tied to 4'b0000.
  - No mask storage is synthesised. All other behaviour is identical.

Test Plan:
- Correct NOR model, SETTLE_CYCLES=2, PASSES=1, start at edge 0 -> vectors change at edges 0, 2, 4, 6; samples at 2, 4, 6, 8; done high for the cycle after edge 8; err_cnt=0, pass=1, fail_mask=0000.
- y_i stuck at 0, defaults -> err_cnt=1, pass=0, fail_mask=4'b0001 (macro on) or 0000 (macro off).
- y_i driven by an OR model, PASSES=3, ERR_W=3 -> 12 mismatches saturate to err_cnt=7, fail_mask=4'b1111, done after edge 24.
- EXPECT_FN=4'b1000 with an AND model -> err_cnt=0, pass=1.
- start pulsed again at edge 3 during a run -> ignored; the run completes at edge 8 exactly as in case 1.
- rst asserted between edges 4 and 5 -> busy, a_o, b_o, err_cnt drop to 0 asynchronously; no done pulse; a fresh start afterwards runs a full clean sweep.
